// File: rtl/grass_pixel_fetch_if.sv
// Sprite/palette ROM read bus between grass_pixel_fetch (master) and its two ROMs (slave).
// Both ROMs return data one Clk after the address is presented.
interface grass_pixel_fetch_if #(
  parameter int unsigned ADDR_W = 14,
  parameter int unsigned IDX_W  = 4
);
  logic [ADDR_W-1:0] rom_addr;
  logic [IDX_W-1:0]  rom_data;
  logic [IDX_W-1:0]  pal_addr;
  logic [23:0]       pal_data;

  modport master (
    output rom_addr,
    output pal_addr,
    input  rom_data,
    input  pal_data
  );

  modport slave (
    input  rom_addr,
    input  pal_addr,
    output rom_data,
    output pal_data
  );
endinterface

// File: rtl/grass_pixel_fetch.sv
// Grass sprite pixel fetch: palette load FSM plus a 2-cycle ROM -> palette -> RGB pipeline.
// Optional GRASS_PAL_RELOAD_EN: reload the palette on each rising edge of frame_clk.
module grass_pixel_fetch #(
  parameter int unsigned ADDR_W    = 14,
  parameter int unsigned IDX_W     = 4,
  parameter int unsigned PAL_DEPTH = 16,
  parameter logic [23:0] BG_COLOR  = 24'h3CBCFC
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              frame_clk,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic              is_grass,
  input  logic [ADDR_W-1:0] grass_addr,
  grass_pixel_fetch_if.master rom,
  output logic              ready,
  output logic [9:0]        pix_X,
  output logic [9:0]        pix_Y,
  output logic              grass_opaque,
  output logic [7:0]        VGA_R,
  output logic [7:0]        VGA_G,
  output logic [7:0]        VGA_B
);

  localparam int unsigned CntW = $clog2(PAL_DEPTH + 1);

  typedef enum logic [0:0] {StLoad, StRun} state_e;

  state_e             state_q;
  logic [CntW-1:0]    cnt_q;
  logic [23:0]        palette_q [PAL_DEPTH];
  logic [IDX_W-1:0]   wr_idx;
  logic [IDX_W-1:0]   pal_next;
  logic               reload;

  logic               s1_grass_q, s2_grass_q;
  logic [9:0]         s1_x_q, s1_y_q, s2_x_q, s2_y_q;
  logic [23:0]        rgb_q;
  logic               opaque_d;

`ifdef GRASS_PAL_RELOAD_EN
  logic fc_meta_q, fc_sync_q, fc_prev_q;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      fc_meta_q <= 1'b0;
      fc_sync_q <= 1'b0;
      fc_prev_q <= 1'b0;
    end else begin
      fc_meta_q <= frame_clk;
      fc_sync_q <= fc_meta_q;
      fc_prev_q <= fc_sync_q;
    end
  end

  assign reload = fc_sync_q & ~fc_prev_q;
`else
  logic unused_frame_clk;
  assign unused_frame_clk = frame_clk;
  assign reload = 1'b0;
`endif

  // Palette data lags pal_addr by one cycle, so entry counter-1 is written each LOAD cycle.
  assign wr_idx   = IDX_W'(cnt_q - 1'b1);
  assign pal_next = (cnt_q >= CntW'(PAL_DEPTH - 1)) ? IDX_W'(PAL_DEPTH - 1)
                                                    : IDX_W'(cnt_q + 1'b1);

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q      <= StLoad;
      cnt_q        <= '0;
      ready        <= 1'b0;
      rom.pal_addr <= '0;
      for (int i = 0; i < int'(PAL_DEPTH); i++) palette_q[i] <= '0;
    end else begin
      unique case (state_q)
        StLoad: begin
          if (cnt_q != '0) palette_q[wr_idx] <= rom.pal_data;
          if (cnt_q == CntW'(PAL_DEPTH)) begin
            state_q <= StRun;
            ready   <= 1'b1;
          end else begin
            cnt_q        <= cnt_q + 1'b1;
            rom.pal_addr <= pal_next;
          end
        end
        StRun: begin
          if (reload) begin
            state_q      <= StLoad;
            cnt_q        <= '0;
            ready        <= 1'b0;
            rom.pal_addr <= '0;
          end
        end
        default: state_q <= StLoad;
      endcase
    end
  end

  assign opaque_d = (state_q == StRun) && s2_grass_q && (rom.rom_data != '0);

  // s1 aligns with the ROM address register, s2 with the returning ROM data.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      rom.rom_addr <= '0;
      s1_grass_q   <= 1'b0;
      s1_x_q       <= '0;
      s1_y_q       <= '0;
      s2_grass_q   <= 1'b0;
      s2_x_q       <= '0;
      s2_y_q       <= '0;
      pix_X        <= '0;
      pix_Y        <= '0;
      grass_opaque <= 1'b0;
      rgb_q        <= BG_COLOR;
    end else begin
      rom.rom_addr <= is_grass ? grass_addr : '0;
      s1_grass_q   <= is_grass;
      s1_x_q       <= DrawX;
      s1_y_q       <= DrawY;
      s2_grass_q   <= s1_grass_q;
      s2_x_q       <= s1_x_q;
      s2_y_q       <= s1_y_q;
      pix_X        <= s2_x_q;
      pix_Y        <= s2_y_q;
      grass_opaque <= opaque_d;
      rgb_q        <= opaque_d ? palette_q[rom.rom_data] : BG_COLOR;
    end
  end

  assign {VGA_R, VGA_G, VGA_B} = rgb_q;

endmodule

// File: tb/tb_grass_pixel_fetch.sv
// Self-checking bench for grass_pixel_fetch: reset/load, directed vector table, mid-RUN reset,
// optional frame reload sequence and randomized traffic against a queue-based reference model.
module tb_grass_pixel_fetch;

  localparam logic [23:0] BG = 24'h3CBCFC;
`ifdef GRASS_PAL_RELOAD_EN
  localparam bit ReloadEn = 1'b1;
`else
  localparam bit ReloadEn = 1'b0;
`endif

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        frame_clk = 1'b0;
  logic [9:0]  DrawX = '0;
  logic [9:0]  DrawY = '0;
  logic        is_grass = 1'b0;
  logic [13:0] grass_addr = '0;
  logic        ready, grass_opaque;
  logic [9:0]  pix_X, pix_Y;
  logic [7:0]  VGA_R, VGA_G, VGA_B;

  grass_pixel_fetch_if bus ();

  grass_pixel_fetch dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .frame_clk    (frame_clk),
    .DrawX        (DrawX),
    .DrawY        (DrawY),
    .is_grass     (is_grass),
    .grass_addr   (grass_addr),
    .rom          (bus),
    .ready        (ready),
    .pix_X        (pix_X),
    .pix_Y        (pix_Y),
    .grass_opaque (grass_opaque),
    .VGA_R        (VGA_R),
    .VGA_G        (VGA_G),
    .VGA_B        (VGA_B)
  );

  always #10 Clk = ~Clk;

  // Synchronous ROM models: sprite index table and palette entry k = 24'h000100*k.
  logic [3:0] sprite_mem [16384];
  initial begin
    bus.rom_data = '0;
    bus.pal_data = '0;
  end
  always @(posedge Clk) begin
    bus.rom_data <= sprite_mem[bus.rom_addr];
    bus.pal_data <= {12'h000, bus.pal_addr, 8'h00};
  end

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pixels flow through a two-deep queue; LOAD is a countdown of 17 edges.
  typedef struct {
    logic        g;
    logic [13:0] a;
    logic [9:0]  x;
    logic [9:0]  y;
  } pix_t;

  pix_t hist[$];
  int   load_left;
  bit   m_ready;
  bit   fc1, fc2;

  task automatic model_reset();
    pix_t z;
    z = '{1'b0, 14'd0, 10'd0, 10'd0};
    hist.delete();
    hist.push_back(z);
    hist.push_back(z);
    load_left = 17;
    m_ready   = 1'b0;
    fc1       = 1'b0;
    fc2       = 1'b0;
  endtask

  task automatic drive(input logic g, input logic [13:0] a, input logic [9:0] x,
                       input logic [9:0] y);
    is_grass   = g;
    grass_addr = a;
    DrawX      = x;
    DrawY      = y;
  endtask

  task automatic step();
    pix_t        p, o;
    bit          was;
    logic [3:0]  idx;
    logic        exp_op;
    logic [23:0] exp_rgb;
    @(posedge Clk);
    p   = '{is_grass, grass_addr, DrawX, DrawY};
    was = m_ready;
    if (load_left > 0) begin
      load_left--;
      if (load_left == 0) m_ready = 1'b1;
    end else if (ReloadEn && fc1 && !fc2) begin
      load_left = 17;
      m_ready   = 1'b0;
    end
    fc2 = fc1;
    fc1 = frame_clk;
    hist.push_back(p);
    o       = hist.pop_front();
    idx     = sprite_mem[o.a];
    exp_op  = was && o.g && (idx != 4'd0);
    exp_rgb = exp_op ? {12'h000, idx, 8'h00} : BG;
    #1;
    chk("ready", 64'(ready), 64'(m_ready));
    chk("rom_addr", 64'(bus.rom_addr), 64'(p.g ? p.a : 14'd0));
    chk("pix_X", 64'(pix_X), 64'(o.x));
    chk("pix_Y", 64'(pix_Y), 64'(o.y));
    chk("grass_opaque", 64'(grass_opaque), 64'(exp_op));
    chk("rgb", 64'({VGA_R, VGA_G, VGA_B}), 64'(exp_rgb));
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_ready"}, 64'(ready), 64'd0);
    chk({tag, "_rgb"}, 64'({VGA_R, VGA_G, VGA_B}), 64'(BG));
    chk({tag, "_opaque"}, 64'(grass_opaque), 64'd0);
    chk({tag, "_pix"}, 64'({pix_X, pix_Y}), 64'd0);
    chk({tag, "_rom_addr"}, 64'(bus.rom_addr), 64'd0);
    chk({tag, "_pal_addr"}, 64'(bus.pal_addr), 64'd0);
  endtask

  task automatic wait_ready(input string tag, input int expect_len);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (ready !== 1'b1 && n < 40);
    chk(tag, 64'(n), 64'(expect_len));
  endtask

  typedef struct {
    logic        g;
    logic [13:0] a;
    logic [9:0]  x;
    logic [9:0]  y;
    logic [23:0] rgb;
    logic        op;
  } vec_t;

  vec_t vt[6];

  initial begin : watchdog
    #1ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 16384; i++) sprite_mem[i] = 4'($urandom_range(0, 15));
    sprite_mem[0]       = 4'd9;
    sprite_mem[14'h123] = 4'd5;
    sprite_mem[14'h200] = 4'd0;
    sprite_mem[14'h300] = 4'd6;
    sprite_mem[14'h400] = 4'd3;
    sprite_mem[14'h500] = 4'd4;
    sprite_mem[14'h600] = 4'd7;

    vt[0] = '{1'b1, 14'h0123, 10'd100, 10'd250, 24'h000500, 1'b1};
    vt[1] = '{1'b1, 14'h0200, 10'd101, 10'd250, BG,         1'b0};
    vt[2] = '{1'b0, 14'h0300, 10'd102, 10'd250, BG,         1'b0};
    vt[3] = '{1'b1, 14'h0400, 10'd103, 10'd251, 24'h000300, 1'b1};
    vt[4] = '{1'b0, 14'h0500, 10'd104, 10'd251, BG,         1'b0};
    vt[5] = '{1'b1, 14'h0600, 10'd105, 10'd251, 24'h000700, 1'b1};

    // Power-on reset: 3 cycles low, released between edges.
    #1 Reset = 1'b0;
    model_reset();
    #4;
    check_reset_values("por");
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    Reset = 1'b1;
    wait_ready("load_len", 17);

    // Directed vectors, outputs aligned two cycles later.
    for (int i = 0; i < 8; i++) begin
      if (i < 6) drive(vt[i].g, vt[i].a, vt[i].x, vt[i].y);
      else drive(1'b0, 14'd0, 10'd0, 10'd0);
      step();
      if (i >= 2) begin
        chk("vec_rgb", 64'({VGA_R, VGA_G, VGA_B}), 64'(vt[i-2].rgb));
        chk("vec_opaque", 64'(grass_opaque), 64'(vt[i-2].op));
        chk("vec_xy", 64'({pix_X, pix_Y}), 64'({vt[i-2].x, vt[i-2].y}));
      end
    end

    // Reset mid-RUN between edges, with grass traffic in flight.
    drive(1'b1, 14'h0123, 10'd7, 10'd8);
    step();
    step();
    #4 Reset = 1'b0;
    #1;
    check_reset_values("mid");
    model_reset();
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    Reset = 1'b1;
    wait_ready("reload_len", 17);

`ifdef GRASS_PAL_RELOAD_EN
    begin : frame_reload
      int n;
      frame_clk = 1'b1;
      n = 0;
      do begin
        step();
        n++;
      end while (ready !== 1'b0 && n < 10);
      chk("fc_fall_lat", 64'(n), 64'd3);
      n = 0;
      do begin
        if (n == 4) frame_clk = 1'b0;
        if (n == 8) frame_clk = 1'b1;
        step();
        n++;
      end while (ready !== 1'b1 && n < 40);
      chk("fc_load_len", 64'(n), 64'd17);
      repeat (5) step();
    end
`endif

    // Randomized traffic; frame_clk toggles occasionally.
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 1)), 14'($urandom_range(0, 16383)),
            10'($urandom_range(0, 1023)), 10'($urandom_range(0, 1023)));
      if ($urandom_range(0, 29) == 0) frame_clk = ~frame_clk;
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
